// File: rtl/uart_rx_pkg.sv
// Shared state encoding and oversampling constants for the UART receive sequencer.
// Prescale is the number of oversample clocks that make up one serial bit.
package uart_rx_pkg;

  localparam int PRESC_8  = 8;
  localparam int PRESC_16 = 16;
  localparam int PRESC_32 = 32;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    DONE
  } rx_state_e;

  // Unsupported ratios fall back to the slowest legal oversampling of 8.
  function automatic int legalize_presc(input int p);
    return (p == PRESC_8 || p == PRESC_16 || p == PRESC_32) ? p : PRESC_8;
  endfunction

endpackage

// File: rtl/uart_rx_fsm_if.sv
// Signal bundle between the receive sequencer and its line/checker/deserializer neighbours.
// master = environment side (line, config, checker results); slave = the sequencer.
interface uart_rx_fsm_if #(
  parameter int PRESC_W = 6
);

  logic               RX_IN;
  logic               PAR_EN;
  logic [PRESC_W-1:0] Prescale;
  logic               start_glitch;
  logic               par_err;
  logic               stp_err;

  logic [PRESC_W-1:0] edge_cnt;
  logic [3:0]         bit_cnt;
  logic               data_samp_en;
  logic               start_check_en;
  logic               par_check_en;
  logic               stop_check_en;
  logic               deser_en;
  logic               data_valid;
  uart_rx_pkg::rx_state_e dbg_state;

  // Handshake: data_valid is a one-cycle strobe with no ready; the consumer must take
  // the byte in that cycle. Each *_en is likewise a one-cycle strobe with no back-pressure,
  // and the matching checker result must be valid exactly one cycle after its enable.
  modport master (
    output RX_IN, PAR_EN, Prescale, start_glitch, par_err, stp_err,
    input  edge_cnt, bit_cnt, data_samp_en, start_check_en, par_check_en,
    input  stop_check_en, deser_en, data_valid, dbg_state
  );

  modport slave (
    input  RX_IN, PAR_EN, Prescale, start_glitch, par_err, stp_err,
    output edge_cnt, bit_cnt, data_samp_en, start_check_en, par_check_en,
    output stop_check_en, deser_en, data_valid, dbg_state
  );

endinterface

// File: rtl/edge_bit_counter.sv
// Oversample (edge) and bit position counters for one UART frame.
// Disabled means cleared: the counters sit at zero whenever the sequencer is not mid-frame.
module edge_bit_counter #(
  parameter int PRESC_W = 6
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               i_enable,
  input  logic [PRESC_W-1:0] i_wrap,
  output logic [PRESC_W-1:0] o_edge_cnt,
  output logic [3:0]         o_bit_cnt
);

  logic [PRESC_W-1:0] r_edge_cnt;
  logic [3:0]         r_bit_cnt;

  always_ff @(posedge CLK) begin
    if (RST || !i_enable) begin
      r_edge_cnt <= '0;
      r_bit_cnt  <= '0;
    end else if (r_edge_cnt == i_wrap) begin
      r_edge_cnt <= '0;
      r_bit_cnt  <= r_bit_cnt + 4'd1;
    end else begin
      r_edge_cnt <= r_edge_cnt + PRESC_W'(1);
    end
  end

  assign o_edge_cnt = r_edge_cnt;
  assign o_bit_cnt  = r_bit_cnt;

endmodule

// File: rtl/uart_rx_fsm.sv
// UART receive sequencer: walks START/DATA/PARITY/STOP, strobes the checkers and the
// deserializer at oversample P-2, and acts on checker results at P-1.
module uart_rx_fsm
  import uart_rx_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int PRESC_W = 6
) (
  input logic         CLK,
  input logic         RST,
  uart_rx_fsm_if.slave bus
);

  rx_state_e          r_state;
  logic [PRESC_W-1:0] r_presc;
  logic               r_par_en;
  logic               r_data_samp_en;
  logic               r_start_check_en;
  logic               r_par_check_en;
  logic               r_stop_check_en;
  logic               r_deser_en;
  logic               r_data_valid;

  logic [PRESC_W-1:0] w_edge_cnt;
  logic [PRESC_W-1:0] w_wrap;
  logic [3:0]         w_bit_cnt;
  logic               w_last_edge;
  logic               w_pre_check;
  logic               w_bits_done;
  logic               w_frame_end;
  logic               w_cnt_en;

  assign w_wrap      = r_presc - PRESC_W'(1);
  assign w_last_edge = (w_edge_cnt == w_wrap);
  assign w_pre_check = (w_edge_cnt == r_presc - PRESC_W'(3));
  assign w_bits_done = (w_bit_cnt == 4'(DATA_W));

  // The counters clear on the edge that ends the frame, so bit_cnt never steps past STOP.
  assign w_frame_end = w_last_edge &&
                       ((r_state == START  && bus.start_glitch) ||
                        (r_state == PARITY && bus.par_err) ||
                        (r_state == STOP));
  assign w_cnt_en    = (r_state != IDLE) && (r_state != DONE) && !w_frame_end;

  edge_bit_counter #(
    .PRESC_W (PRESC_W)
  ) u_counter (
    .CLK        (CLK),
    .RST        (RST),
    .i_enable   (w_cnt_en),
    .i_wrap     (w_wrap),
    .o_edge_cnt (w_edge_cnt),
    .o_bit_cnt  (w_bit_cnt)
  );

  // Strobes are registered one edge early (at P-3) so they are high while edge_cnt == P-2.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state          <= IDLE;
      r_presc          <= PRESC_W'(PRESC_8);
      r_par_en         <= 1'b0;
      r_data_samp_en   <= 1'b0;
      r_start_check_en <= 1'b0;
      r_par_check_en   <= 1'b0;
      r_stop_check_en  <= 1'b0;
      r_deser_en       <= 1'b0;
      r_data_valid     <= 1'b0;
    end else begin
      r_start_check_en <= 1'b0;
      r_par_check_en   <= 1'b0;
      r_stop_check_en  <= 1'b0;
      r_deser_en       <= 1'b0;
      r_data_valid     <= 1'b0;
      case (r_state)
        IDLE: begin
          if (!bus.RX_IN) begin
            r_state        <= START;
            r_presc        <= PRESC_W'(legalize_presc(int'(bus.Prescale)));
            r_par_en       <= bus.PAR_EN;
            r_data_samp_en <= 1'b1;
          end
        end
        START: begin
          r_start_check_en <= w_pre_check;
          if (w_last_edge) begin
            if (bus.start_glitch) begin
              r_state        <= IDLE;
              r_data_samp_en <= 1'b0;
            end else begin
              r_state <= DATA;
            end
          end
        end
        DATA: begin
          r_deser_en <= w_pre_check;
          if (w_last_edge && w_bits_done) begin
            r_state <= r_par_en ? PARITY : STOP;
          end
        end
        PARITY: begin
          r_par_check_en <= w_pre_check;
          if (w_last_edge) begin
            if (bus.par_err) begin
              r_state        <= IDLE;
              r_data_samp_en <= 1'b0;
            end else begin
              r_state <= STOP;
            end
          end
        end
        STOP: begin
          r_stop_check_en <= w_pre_check;
          if (w_last_edge) begin
            if (bus.stp_err) begin
              r_state        <= IDLE;
              r_data_samp_en <= 1'b0;
            end else begin
              r_state      <= DONE;
              r_data_valid <= 1'b1;
            end
          end
        end
        DONE: begin
          // A low line here is the next start bit; latched Prescale/PAR_EN carry over.
          if (!bus.RX_IN) begin
            r_state <= START;
          end else begin
            r_state        <= IDLE;
            r_data_samp_en <= 1'b0;
          end
        end
        default: begin
          r_state        <= IDLE;
          r_data_samp_en <= 1'b0;
        end
      endcase
    end
  end

  assign bus.edge_cnt       = w_edge_cnt;
  assign bus.bit_cnt        = w_bit_cnt;
  assign bus.data_samp_en   = r_data_samp_en;
  assign bus.start_check_en = r_start_check_en;
  assign bus.par_check_en   = r_par_check_en;
  assign bus.stop_check_en  = r_stop_check_en;
  assign bus.deser_en       = r_deser_en;
  assign bus.data_valid     = r_data_valid;
  assign bus.dbg_state      = r_state;

endmodule
